// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared prescaled timebase (edge or center aligned), per-channel duty compare.
// Latency: pwm_output is registered and lags the counter by one clk; period_end pulses the clk after a boundary tick.
// Backpressure: none; load is a strobe into a single pending slot, applied atomically at the next period boundary.
module pwm_multi_channel #(
    parameter int CHANNELS        = 4,
    parameter int WORD_LENGTH     = 8,
    parameter int PRESCALE_LENGTH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic [PRESCALE_LENGTH-1:0]      i_prescale,
    input  logic [WORD_LENGTH-1:0]          i_period,
    input  logic [CHANNELS*WORD_LENGTH-1:0] i_duty,
    input  logic                            i_center_mode,
    input  logic                            i_load,
    output logic [CHANNELS-1:0]             o_pwm_output,
    output logic                            o_period_end,
    output logic                            o_load_pending
);

    // One complete timebase configuration; pending and active copies share this layout
    typedef struct packed {
        logic                            center;
        logic [PRESCALE_LENGTH-1:0]      prescale;
        logic [WORD_LENGTH-1:0]          period;
        logic [CHANNELS*WORD_LENGTH-1:0] duty;
    } cfg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [WORD_LENGTH-1:0]     CNT_ONE = WORD_LENGTH'(1);
    localparam logic [PRESCALE_LENGTH-1:0] PRE_ONE = PRESCALE_LENGTH'(1);

    // FSM
    state_t r_state;
    state_t w_state_nxt;
    logic   w_run;

    // Timebase
    logic [PRESCALE_LENGTH-1:0] r_pre;
    logic [WORD_LENGTH-1:0]     r_cnt;
    dir_t                       r_dir;
    logic                       w_tick;
    logic [WORD_LENGTH-1:0]     w_cnt_nxt;
    dir_t                       w_dir_nxt;
    logic                       w_boundary;

    // Settings
    cfg_t w_cfg_in;
    cfg_t r_cfg_pend;
    cfg_t r_cfg_act;
    logic r_load_pending;

    // Outputs
    logic [CHANNELS-1:0] w_cmp;
    logic [CHANNELS-1:0] r_pwm;
    logic                r_period_end;

    assign w_cfg_in = '{center:   i_center_mode,
                        prescale: i_prescale,
                        period:   i_period,
                        duty:     i_duty};

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; w_run marks an edge on which the timebase actually advances.
    // A RUN cycle with start low behaves like IDLE so the abort is immediate.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_start) begin
                    w_run = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter successor for the active mode; only consumed on a tick.
    // Returning to zero always re-arms the up direction, which also covers P changes at a boundary.
    always_comb begin
        w_tick    = w_run && (r_pre == r_cfg_act.prescale);
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (!r_cfg_act.center) begin
            w_cnt_nxt = (r_cnt >= r_cfg_act.period) ? '0 : (r_cnt + CNT_ONE);
        end else if (r_dir == DIR_UP) begin
            if (r_cnt >= r_cfg_act.period) begin
                w_cnt_nxt = (r_cfg_act.period == '0) ? '0 : (r_cfg_act.period - CNT_ONE);
                w_dir_nxt = DIR_DOWN;
            end else begin
                w_cnt_nxt = r_cnt + CNT_ONE;
            end
        end else begin
            w_cnt_nxt = (r_cnt == '0) ? '0 : (r_cnt - CNT_ONE);
        end
        if (w_cnt_nxt == '0) begin
            w_dir_nxt = DIR_UP;
        end
        w_boundary = w_tick && (w_cnt_nxt == '0);
    end

    // Prescaler, counter and direction; all cleared whenever the timebase is not running
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pre <= '0;
            r_cnt <= '0;
            r_dir <= DIR_UP;
        end else if (!w_run) begin
            r_pre <= '0;
            r_cnt <= '0;
            r_dir <= DIR_UP;
        end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
        end else begin
            r_pre <= r_pre + PRE_ONE;
        end
    end

    // Unsigned per-channel compare against the active duty values
    always_comb begin
        w_cmp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cmp[i] = (r_cnt < r_cfg_act.duty[i*WORD_LENGTH +: WORD_LENGTH]);
        end
    end

    // Registered waveforms and boundary pulse; forced low outside RUN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pwm        <= '0;
            r_period_end <= 1'b0;
        end else if (!w_run) begin
            r_pwm        <= '0;
            r_period_end <= 1'b0;
        end else begin
            r_pwm        <= w_cmp;
            r_period_end <= w_boundary;
        end
    end

    // Pending slot always follows a load strobe, in any state
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cfg_pend <= '0;
        end else if (i_load) begin
            r_cfg_pend <= w_cfg_in;
        end
    end

    // Active settings: transparent to loads while idle, swapped only at a boundary while running.
    // A load on the boundary edge lands in pending, so the swap uses the previous capture.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cfg_act <= '0;
        end else if (!w_run) begin
            r_cfg_act <= i_load ? w_cfg_in : r_cfg_pend;
        end else if (w_boundary && r_load_pending) begin
            r_cfg_act <= r_cfg_pend;
        end
    end

    // Pending flag: set by a load while running, cleared by the boundary that consumes it
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_load_pending <= 1'b0;
        end else if (!w_run) begin
            r_load_pending <= 1'b0;
        end else if (i_load) begin
            r_load_pending <= 1'b1;
        end else if (w_boundary) begin
            r_load_pending <= 1'b0;
        end
    end

    assign o_pwm_output   = r_pwm;
    assign o_period_end   = r_period_end;
    assign o_load_pending = r_load_pending;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: directed scenarios plus randomized traffic against a tick/position model.
// Latency: outputs sampled on the falling clock edge, one clk after the model's rising-edge update.
// Backpressure: none; loads and start are driven freely from the bench.
module tb_pwm_multi_channel;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int PL = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [PL-1:0]   prescale;
    logic [W-1:0]    period;
    logic [CH*W-1:0] duty;
    logic            center;
    logic            load;
    logic [CH-1:0]   o_pwm_output;
    logic            o_period_end;
    logic            o_load_pending;

    int n_cmp  = 0;
    int n_fail = 0;

    pwm_multi_channel #(
        .CHANNELS(CH), .WORD_LENGTH(W), .PRESCALE_LENGTH(PL)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_prescale(prescale),
        .i_period(period), .i_duty(duty), .i_center_mode(center), .i_load(load),
        .o_pwm_output(o_pwm_output), .o_period_end(o_period_end), .o_load_pending(o_load_pending)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Position m_pos counts ticks since the period start; the counter value is derived from it.
    bit              m_run;
    int              m_pos, m_sub;
    int              a_pre, a_per, p_pre, p_per;
    bit              a_cen, p_cen;
    logic [CH*W-1:0] a_duty, p_duty;
    bit              m_lp, m_pe;
    logic [CH-1:0]   m_pwm;

    function automatic int len_of(input int p, input bit cen);
        if (p == 0) return 1;
        return cen ? 2 * p : p + 1;
    endfunction

    function automatic int cnt_of(input int pos, input int p, input bit cen);
        if (!cen || pos <= p) return pos;
        return 2 * p - pos;
    endfunction

    // True when the coming rising edge is a boundary tick
    function automatic bit next_bnd();
        return m_run && start && (m_sub == a_pre) && (m_pos == len_of(a_per, a_cen) - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int c;
        bit tick, bnd;
        if (!rst_n) begin
            m_run = 0; m_pos = 0; m_sub = 0; m_lp = 0; m_pe = 0; m_pwm = '0;
            a_pre = 0; a_per = 0; a_cen = 0; a_duty = '0;
            p_pre = 0; p_per = 0; p_cen = 0; p_duty = '0;
        end else if (!m_run || !start) begin
            m_pwm = '0; m_pe = 0; m_pos = 0; m_sub = 0; m_lp = 0;
            if (load) begin
                p_pre = int'(prescale); p_per = int'(period); p_cen = center; p_duty = duty;
            end
            a_pre = p_pre; a_per = p_per; a_cen = p_cen; a_duty = p_duty;
            m_run = !m_run && start;
        end else begin
            c = cnt_of(m_pos, a_per, a_cen);
            for (int i = 0; i < CH; i++) m_pwm[i] = (c < int'(a_duty[i*W +: W]));
            tick = (m_sub == a_pre);
            bnd  = tick && (m_pos == len_of(a_per, a_cen) - 1);
            if (tick) begin
                m_sub = 0;
                m_pos = bnd ? 0 : m_pos + 1;
            end else begin
                m_sub = m_sub + 1;
            end
            m_pe = bnd;
            if (bnd && m_lp) begin
                a_pre = p_pre; a_per = p_per; a_cen = p_cen; a_duty = p_duty; m_lp = 0;
            end
            if (load) begin
                p_pre = int'(prescale); p_per = int'(period); p_cen = center; p_duty = duty; m_lp = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input int pr, input int pe, input logic [CH*W-1:0] d, input bit cen);
        prescale = PL'(pr); period = W'(pe); duty = d; center = cen;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; load = 1'b0; prescale = '0; period = '0; duty = '0; center = 1'b0;
        #12;
        n_cmp += 3;
        if (o_pwm_output !== '0) begin n_fail++; $display("FAIL reset_pwm got %b want 0", o_pwm_output); end
        if (o_period_end !== 1'b0) begin n_fail++; $display("FAIL reset_pe got %b want 0", o_period_end); end
        if (o_load_pending !== 1'b0) begin n_fail++; $display("FAIL reset_lp got %b want 0", o_load_pending); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        n_cmp += 2;
        if (o_pwm_output !== '0) begin n_fail++; $display("FAIL idle_pwm got %b want 0", o_pwm_output); end
        if (o_period_end !== 1'b0) begin n_fail++; $display("FAIL idle_pe got %b want 0", o_period_end); end
    endtask

    task automatic test_edge();
        int hi0, hi1, hi2, hi3, npe;
        hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0; npe = 0;
        start = 1'b0;
        apply(0, 9, {8'd9, 8'd10, 8'd0, 8'd3}, 1'b0);
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc();
            n_cmp += 3;
            if (o_pwm_output !== m_pwm) begin n_fail++; $display("FAIL edge_pwm k=%0d got %b want %b", k, o_pwm_output, m_pwm); end
            if (o_period_end !== m_pe) begin n_fail++; $display("FAIL edge_pe k=%0d got %b want %b", k, o_period_end, m_pe); end
            if (o_load_pending !== m_lp) begin n_fail++; $display("FAIL edge_lp k=%0d got %b want %b", k, o_load_pending, m_lp); end
            if (k >= 5 && k < 35) begin
                if (o_pwm_output[0]) hi0++;
                if (o_pwm_output[1]) hi1++;
                if (o_pwm_output[2]) hi2++;
                if (o_pwm_output[3]) hi3++;
                if (o_period_end) npe++;
            end
        end
        n_cmp += 5;
        if (hi0 !== 9)  begin n_fail++; $display("FAIL edge_hi0 got %0d want 9", hi0); end
        if (hi1 !== 0)  begin n_fail++; $display("FAIL edge_hi1 got %0d want 0", hi1); end
        if (hi2 !== 30) begin n_fail++; $display("FAIL edge_hi2 got %0d want 30", hi2); end
        if (hi3 !== 27) begin n_fail++; $display("FAIL edge_hi3 got %0d want 27", hi3); end
        if (npe !== 3)  begin n_fail++; $display("FAIL edge_npe got %0d want 3", npe); end
    endtask

    task automatic test_center();
        int hi0, npe;
        hi0 = 0; npe = 0;
        start = 1'b0;
        cyc();
        apply(1, 4, {24'd0, 8'd2}, 1'b1);
        start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            cyc();
            n_cmp += 3;
            if (o_pwm_output !== m_pwm) begin n_fail++; $display("FAIL ctr_pwm k=%0d got %b want %b", k, o_pwm_output, m_pwm); end
            if (o_period_end !== m_pe) begin n_fail++; $display("FAIL ctr_pe k=%0d got %b want %b", k, o_period_end, m_pe); end
            if (o_load_pending !== m_lp) begin n_fail++; $display("FAIL ctr_lp k=%0d got %b want %b", k, o_load_pending, m_lp); end
            if (k >= 10 && k < 58) begin
                if (o_pwm_output[0]) hi0++;
                if (o_period_end) npe++;
            end
        end
        n_cmp += 2;
        if (hi0 !== 18) begin n_fail++; $display("FAIL ctr_hi0 got %0d want 18", hi0); end
        if (npe !== 3)  begin n_fail++; $display("FAIL ctr_npe got %0d want 3", npe); end
    endtask

    task automatic test_load_mid();
        bit found;
        int drop, hi, pe5, pe10;
        found = 0; drop = -1; hi = 0; pe5 = 0; pe10 = 0;
        start = 1'b0;
        cyc();
        apply(0, 9, {24'd0, 8'd3}, 1'b0);
        start = 1'b1;
        for (int k = 0; k < 60 && !found; k++) begin
            cyc();
            if (m_run && start && m_pos == 5) found = 1;
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL lm_wait got timeout want counter=5"); end
        period = 8'd4; duty = {24'd0, 8'd1}; load = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            load = 1'b0;
            n_cmp += 3;
            if (o_pwm_output !== m_pwm) begin n_fail++; $display("FAIL lm_pwm k=%0d got %b want %b", k, o_pwm_output, m_pwm); end
            if (o_period_end !== m_pe) begin n_fail++; $display("FAIL lm_pe k=%0d got %b want %b", k, o_period_end, m_pe); end
            if (o_load_pending !== m_lp) begin n_fail++; $display("FAIL lm_lp k=%0d got %b want %b", k, o_load_pending, m_lp); end
            if (k == 1) begin
                n_cmp++;
                if (o_load_pending !== 1'b1) begin n_fail++; $display("FAIL lm_lp_set got %b want 1", o_load_pending); end
            end
            if (drop < 0 && o_load_pending === 1'b0) drop = k;
            if (k == 5)  pe5  = int'(o_period_end);
            if (k == 10) pe10 = int'(o_period_end);
            if (k >= 6 && k <= 10 && o_pwm_output[0]) hi++;
        end
        n_cmp += 4;
        if (drop !== 5) begin n_fail++; $display("FAIL lm_drop got %0d want 5", drop); end
        if (pe5 !== 1)  begin n_fail++; $display("FAIL lm_pe5 got %0d want 1", pe5); end
        if (pe10 !== 1) begin n_fail++; $display("FAIL lm_pe10 got %0d want 1", pe10); end
        if (hi !== 1)   begin n_fail++; $display("FAIL lm_hi got %0d want 1", hi); end
    endtask

    task automatic test_back_to_back();
        bit found;
        int hia, hib, lp10, lp11;
        found = 0; hia = 0; hib = 0; lp10 = 0; lp11 = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc();
            if (o_period_end === 1'b1) found = 1;
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL b2b_wait1 got timeout want period_end"); end
        period = 8'd9; duty = {24'd0, 8'd5}; load = 1'b1;
        cyc();
        load = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (next_bnd()) found = 1;
            else cyc();
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL b2b_wait2 got timeout want boundary"); end
        duty = {24'd0, 8'd7}; load = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            cyc();
            load = 1'b0;
            n_cmp += 3;
            if (o_pwm_output !== m_pwm) begin n_fail++; $display("FAIL b2b_pwm k=%0d got %b want %b", k, o_pwm_output, m_pwm); end
            if (o_period_end !== m_pe) begin n_fail++; $display("FAIL b2b_pe k=%0d got %b want %b", k, o_period_end, m_pe); end
            if (o_load_pending !== m_lp) begin n_fail++; $display("FAIL b2b_lp k=%0d got %b want %b", k, o_load_pending, m_lp); end
            if (k == 1) begin
                n_cmp += 2;
                if (o_load_pending !== 1'b1) begin n_fail++; $display("FAIL b2b_lp_keep got %b want 1", o_load_pending); end
                if (o_period_end !== 1'b1) begin n_fail++; $display("FAIL b2b_pe1 got %b want 1", o_period_end); end
            end
            if (k >= 2 && k <= 11 && o_pwm_output[0]) hia++;
            if (k >= 12 && k <= 21 && o_pwm_output[0]) hib++;
            if (k == 10) lp10 = int'(o_load_pending);
            if (k == 11) lp11 = int'(o_load_pending);
        end
        n_cmp += 4;
        if (hia !== 5)  begin n_fail++; $display("FAIL b2b_hi5 got %0d want 5", hia); end
        if (hib !== 7)  begin n_fail++; $display("FAIL b2b_hi7 got %0d want 7", hib); end
        if (lp10 !== 1) begin n_fail++; $display("FAIL b2b_lp10 got %0d want 1", lp10); end
        if (lp11 !== 0) begin n_fail++; $display("FAIL b2b_lp11 got %0d want 0", lp11); end
    endtask

    task automatic test_abort_reset();
        bit found;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc();
            if (m_run && start && m_pos == 6) found = 1;
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL ab_wait got timeout want counter=6"); end
        start = 1'b0;
        cyc();
        n_cmp += 2;
        if (o_pwm_output !== '0) begin n_fail++; $display("FAIL ab_pwm got %b want 0", o_pwm_output); end
        if (o_period_end !== 1'b0) begin n_fail++; $display("FAIL ab_pe got %b want 0", o_period_end); end
        start = 1'b1;
        cyc();
        cyc();
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (o_pwm_output !== '0) begin n_fail++; $display("FAIL ar_pwm got %b want 0", o_pwm_output); end
        if (o_period_end !== 1'b0) begin n_fail++; $display("FAIL ar_pe got %b want 0", o_period_end); end
        if (o_load_pending !== 1'b0) begin n_fail++; $display("FAIL ar_lp got %b want 0", o_load_pending); end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            n_cmp += 4;
            if (o_pwm_output !== '0) begin n_fail++; $display("FAIL rs_pwm0 k=%0d got %b want 0", k, o_pwm_output); end
            if (o_pwm_output !== m_pwm) begin n_fail++; $display("FAIL rs_pwm k=%0d got %b want %b", k, o_pwm_output, m_pwm); end
            if (o_period_end !== m_pe) begin n_fail++; $display("FAIL rs_pe k=%0d got %b want %b", k, o_period_end, m_pe); end
            if (o_load_pending !== m_lp) begin n_fail++; $display("FAIL rs_lp k=%0d got %b want %b", k, o_load_pending, m_lp); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 99) != 0);
            load  = ($urandom_range(0, 15) == 0);
            if (load) begin
                prescale = PL'($urandom_range(0, 3));
                period   = W'($urandom_range(0, 12));
                center   = $urandom_range(0, 1) == 1;
                for (int i = 0; i < CH; i++) duty[i*W +: W] = W'($urandom_range(0, 14));
            end
            cyc();
            n_cmp += 3;
            if (o_pwm_output !== m_pwm) begin n_fail++; $display("FAIL rnd_pwm k=%0d got %b want %b", k, o_pwm_output, m_pwm); end
            if (o_period_end !== m_pe) begin n_fail++; $display("FAIL rnd_pe k=%0d got %b want %b", k, o_period_end, m_pe); end
            if (o_load_pending !== m_lp) begin n_fail++; $display("FAIL rnd_lp k=%0d got %b want %b", k, o_load_pending, m_lp); end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_load_mid();
        test_back_to_back();
        test_abort_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent PWM outputs sharing one timebase.
REQ-002 Parameter WORD_LENGTH, default 8: width of the period, counter and each duty value.
REQ-003 Parameter PRESCALE_LENGTH, default 4: width of the clock prescaler reload value.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  level enable; 1 = run, 0 = idle.
REQ-007 prescale  input  PRESCALE_LENGTH  the counter advances once every prescale+1 clk cycles.
REQ-008 period  input  WORD_LENGTH  counter top value P.
REQ-009 duty  input  CHANNELS*WORD_LENGTH  per-channel duty D[i], in bits [i*WORD_LENGTH +: WORD_LENGTH].
REQ-010 center_mode  input  1  0 = edge-aligned (up count), 1 = center-aligned (up/down count).
REQ-011 load  input  1  single-cycle strobe that captures prescale/period/duty/center_mode into pending registers.
REQ-012 pwm_output  output  CHANNELS  registered PWM waveforms.
REQ-013 period_end  output  1  one-cycle pulse at each period boundary.
REQ-014 load_pending  output  1  high while captured settings await application.

Function
REQ-015 FSM states: IDLE and RUN; IDLE->RUN on start=1, RUN->IDLE on start=0, with effect at the same clk edge.
REQ-016 In IDLE: counter=0, prescaler=0, direction=up, pwm_output=0, period_end=0; pending settings are copied into the active registers every cycle, so a load strobe takes effect immediately.
REQ-017 In RUN, a tick is asserted when prescaler==active prescale; on a tick the prescaler clears, otherwise it increments.
REQ-018 Edge mode: on each tick the counter goes 0,1,...,P and then wraps to 0; the period is (P+1) ticks.
REQ-019 Center mode: on each tick the counter goes 0 up to P, then down to 1, then back to 0; the period is 2P ticks for P>=1.
REQ-020 P=0 in either mode: the counter holds 0, and every tick is a period boundary.
REQ-021 pwm_output[i] is registered as (counter < active D[i]) and lags the counter by one clk cycle.
REQ-022 The compare is unsigned on WORD_LENGTH bits: D=0 gives constant 0; D>P gives constant 1.
REQ-023 In edge mode the high time is D ticks; in center mode it is 2D-1 ticks for 1<=D<=P.
REQ-024 A period boundary is the tick on which the counter returns to 0.
REQ-025 period_end pulses in the clk cycle after each boundary tick.
REQ-026 load in RUN: the pending registers capture the inputs, load_pending=1, and active settings apply atomically at the next boundary tick, after which load_pending=0.
REQ-027 A second load before the boundary overwrites pending; only the last capture is applied.
REQ-028 load coincident with a boundary tick: the boundary applies the old pending values, the new values become pending, and load_pending remains 1.
REQ-029 When P is changed at a boundary, counting restarts at 0 using the new P; the direction resets to up.
REQ-030 start=0 mid-period aborts immediately: the next cycle is IDLE with outputs low; no period_end is emitted.

Reset
REQ-031 reset=0 asynchronously forces: IDLE, counter=0, prescaler=0, pwm_output=0, period_end=0, load_pending=0.
REQ-032 reset=0 also clears all pending and active settings to 0 (prescale=0, P=0, D=0, edge mode).
REQ-033 Release of reset takes effect at the next clk edge; the first RUN cycle requires start=1 sampled after release.

Verification
REQ-034 Edge mode, prescale=0, P=9, D[0]=3, D[1]=0, D[2]=10, D[3]=9 -> a 10-cycle period; ch0 high 3 cycles, ch1 always low, ch2 always high, ch3 high 9 cycles; period_end every 10 cycles.
REQ-035 Center mode, prescale=1, P=4, D[0]=2 -> an 8-tick (16-clk) period; ch0 high 3 ticks (6 clk), symmetric about counter=0; period_end every 16 clk.
REQ-036 RUN with P=9, D[0]=3; load P=4, D[0]=1 at counter=5 -> load_pending=1, the current period completes unchanged, then a 5-cycle period with 1 high cycle, and load_pending=0 after the boundary.
REQ-037 Two loads in one period (D[0]=5, then D[0]=7), with the second coincident with the boundary tick -> the next period uses 5, the following period uses 7.
REQ-038 start drops at counter=6, then reset asserted mid-clock -> pwm_output=0 the next cycle and no period_end; reset clears immediately without a clock, and after restart all outputs stay 0 until a load.
